// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, functs, FSM states, ALU ops.
// Pure declarations plus two small decode helpers; no logic of its own.
// Imported by the core and the register file.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Encodings are visible on state_out, so they are fixed explicitly.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  function automatic alu_op_e funct_to_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // An R-type word is only legal with one of the five supported functs.
  function automatic logic op_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                       (fn == FN_OR)  || (fn == FN_SLT);
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_core_regfile.sv
// Register file: 2 combinational read ports, 1 write port on the rising clock edge.
// Reads are zero-latency; writes land at the end of the write cycle.
// No backpressure; index 0 always reads zero and ignores writes.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_b
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] regs_q [NREG];
  logic [AW-1:0]   wa, ra, rb;

  // Indices above NREG-1 alias onto the low bits.
  assign wa = waddr[AW-1:0];
  assign ra = raddr_a[AW-1:0];
  assign rb = raddr_b[AW-1:0];

  assign rdata_a = (ra == '0) ? '0 : regs_q[ra];
  assign rdata_b = (rb == '0) ? '0 : regs_q[rb];

  // Register array: cleared on reset, written once per WB cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs_q[wa] <= wdata;
    end
  end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: shared ALU, FSM fetch/decode/exec/mem/wb, unified memory port.
// CPI j 2, beq 3, sw/R/addi 4, lw 5, plus one cycle per memory wait state.
// Memory requests are held stable until mem_ack; the FSM simply stalls meanwhile.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic [XLEN-1:0] pc_out,
  output logic [2:0]      state_out,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, aluout_q, aluout_d, mdr_q, mdr_d;
  logic [31:0]     ir_q, ir_d;

  logic [5:0]      opcode, funct;
  logic [4:0]      rs, rt, rd;
  logic [XLEN-1:0] sext_imm, rf_a, rf_b, rf_wdata, alu_a, alu_b, alu_y;
  logic [4:0]      rf_waddr;
  logic            rf_we, mem_xfer;
  alu_op_e         alu_op;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign sext_imm = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};

  // Outputs decode straight from registered state so they stay put while waiting for ack;
  // gating with rst drops a pending request the moment reset rises.
  assign mem_req   = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !rst;
  assign mem_we    = (state_q == ST_MEM) && (opcode == OP_SW) && !rst;
  assign mem_addr  = (state_q == ST_MEM) ? aluout_q : pc_q;
  assign mem_wdata = b_q;
  assign mem_xfer  = mem_req && mem_ack;
  assign pc_out    = pc_q;
  assign state_out = state_q;
  assign halted    = (state_q == ST_HALT);

  mips_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rs),
    .rdata_a (rf_a),
    .raddr_b (rt),
    .rdata_b (rf_b)
  );

  // Operand steering for the single ALU: PC+4 in fetch, branch target in decode, the op in exec.
  always_comb begin
    alu_a  = pc_q;
    alu_b  = XLEN'(4);
    alu_op = ALU_ADD;
    case (state_q)
      ST_DECODE: alu_b = {sext_imm[XLEN-3:0], 2'b00};
      ST_EXEC: begin
        alu_a = a_q;
        if (opcode == OP_RTYPE) begin
          alu_b  = b_q;
          alu_op = funct_to_alu(funct);
        end else begin
          alu_b = sext_imm;
        end
      end
      default: ;
    endcase
  end

  // Shared ALU; arithmetic wraps, slt is a signed compare.
  always_comb begin
    alu_y = alu_a + alu_b;
    case (alu_op)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: ;
    endcase
  end

  // FSM next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = aluout_q;
    case (state_q)
      ST_FETCH: if (mem_xfer) begin
        ir_d    = mem_rdata[31:0];
        pc_d    = alu_y;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        a_d      = rf_a;
        b_d      = rf_b;
        aluout_d = alu_y;
        if (!op_legal(opcode, funct)) begin
          state_d = ST_HALT;
        end else if (opcode == OP_J) begin
          pc_d    = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (opcode == OP_BEQ) begin
          if (a_q == b_q) pc_d = aluout_q;
          state_d = ST_FETCH;
        end else begin
          aluout_d = alu_y;
          state_d  = ((opcode == OP_LW) || (opcode == OP_SW)) ? ST_MEM : ST_WB;
        end
      end
      ST_MEM: if (mem_xfer) begin
        if (opcode == OP_LW) begin
          mdr_d   = mem_rdata;
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        rf_we = 1'b1;
        if (opcode == OP_RTYPE) rf_waddr = rd;
        if (opcode == OP_LW)    rf_wdata = mdr_q;
        state_d = ST_FETCH;
      end
      ST_HALT: ;
      default: state_d = ST_HALT;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed programs, bus-access scoreboard.
module tb_mips_multicycle_core;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ack, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic [2:0]  state_out;

  logic [31:0] mem [0:255];
  int          data_wait;
  int          wcnt;
  acc_t        sb[$];
  int          checks, errors, req_cnt, wr_cnt;

  always #5 clk = ~clk;

  mips_multicycle_core #(.XLEN(32), .NREG(32), .PC_RESET(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pc_out    (pc_out),
    .state_out (state_out),
    .halted    (halted)
  );

  // Memory model: fetches below 0x40 are zero-wait, data at/above 0x40 waits data_wait cycles.
  assign mem_ack   = mem_req && (wcnt >= ((mem_addr >= 32'h40) ? data_wait : 0));
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk or posedge rst) begin
    if (rst || !mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_r(logic [5:0] fn, int rs, int rt, int rd);
    return {OP_R, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_rd(input logic [31:0] a);
    sb.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    sb.push_back('{we: 1'b1, addr: a, wdata: d});
  endtask

  // Every completed bus access is compared against the next expected one.
  task automatic monitor();
    acc_t e;
    forever begin
      @(negedge clk);
      if (mem_req) req_cnt++;
      if (mem_req && mem_we) wr_cnt++;
      if (mem_req && mem_ack) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL sb_unexpected: observed access at %h, expected none", mem_addr);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("acc_we", 32'(mem_we), 32'(e.we));
          chk("acc_addr", mem_addr, e.addr);
          if (e.we) chk("acc_wdata", mem_wdata, e.wdata);
        end
      end
    end
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = ILLEGAL;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_halt(input string tag, input logic [31:0] pc_exp);
    int n = 0;
    int r0;
    while (halted !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "_halted"}, 32'(halted), 32'd1);
    chk({tag, "_state"}, 32'(state_out), 32'd7);
    chk({tag, "_pc"}, pc_out, pc_exp);
    r0 = req_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_no_req"}, 32'(req_cnt - r0), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int w0;
    checks = 0; errors = 0; req_cnt = 0; wr_cnt = 0; data_wait = 0;
    rst = 1'b0;
    fork monitor(); join_none
    #1;

    // Reset state
    hold_reset();
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_pc", pc_out, 32'h0);

    // Program 1: zero-wait ALU ops and stores
    mem[0]  = enc_i(OP_ADDI, 0, 1, 5);
    mem[1]  = enc_i(OP_ADDI, 0, 2, 7);
    mem[2]  = enc_r(6'h20, 1, 2, 3);
    mem[3]  = enc_i(OP_SW, 0, 3, 'h80);
    mem[4]  = enc_r(6'h22, 3, 1, 4);
    mem[5]  = enc_r(6'h24, 3, 2, 5);
    mem[6]  = enc_r(6'h25, 1, 2, 6);
    mem[7]  = enc_i(OP_SW, 0, 4, 'h84);
    mem[8]  = enc_i(OP_SW, 0, 5, 'h88);
    mem[9]  = enc_i(OP_SW, 0, 6, 'h8C);
    exp_rd(32'h00); exp_rd(32'h04); exp_rd(32'h08); exp_rd(32'h0C);
    exp_wr(32'h80, 32'd12);
    exp_rd(32'h10); exp_rd(32'h14); exp_rd(32'h18); exp_rd(32'h1C);
    exp_wr(32'h84, 32'd7);
    exp_rd(32'h20);
    exp_wr(32'h88, 32'd4);
    exp_rd(32'h24);
    exp_wr(32'h8C, 32'd7);
    exp_rd(32'h28);
    w0 = wr_cnt;
    release_reset();
    #1;
    chk("p1_first_req", 32'(mem_req), 32'd1);
    chk("p1_first_addr", mem_addr, 32'h0);
    repeat (12) @(posedge clk);
    #1;
    chk("p1_12cyc_pc", pc_out, 32'd12);
    chk("p1_12cyc_state", 32'(state_out), 32'd0);
    check_halt("p1", 32'h2C);
    chk("p1_write_cycles", 32'(wr_cnt - w0), 32'd4);

    // Program 2: lw with data-side wait states, then store the loaded value
    hold_reset();
    data_wait = 3;
    mem[0]  = enc_i(OP_LW, 0, 4, 'h40);
    mem[1]  = enc_i(OP_SW, 0, 4, 'h44);
    mem[16] = 32'hDEAD_BEEF;
    exp_rd(32'h00); exp_rd(32'h40); exp_rd(32'h04);
    exp_wr(32'h44, 32'hDEAD_BEEF);
    exp_rd(32'h08);
    release_reset();
    repeat (3) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("p2_hold_req", 32'(mem_req), 32'd1);
      chk("p2_hold_we", 32'(mem_we), 32'd0);
      chk("p2_hold_addr", mem_addr, 32'h40);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("p2_8cyc_state", 32'(state_out), 32'd0);
    chk("p2_8cyc_pc", pc_out, 32'h4);
    check_halt("p2", 32'h0C);

    // Program 3: slt, r0 discard, beq taken/not taken, j
    hold_reset();
    data_wait = 0;
    mem[0]  = enc_i(OP_ADDI, 0, 1, -1);
    mem[1]  = enc_i(OP_ADDI, 0, 2, 1);
    mem[2]  = enc_r(6'h2A, 1, 2, 3);
    mem[3]  = enc_i(OP_ADDI, 0, 0, 9);
    mem[4]  = enc_i(OP_BEQ, 1, 1, 2);
    mem[7]  = enc_i(OP_BEQ, 1, 2, 5);
    mem[8]  = enc_i(OP_SW, 0, 3, 'h80);
    mem[9]  = enc_i(OP_SW, 0, 0, 'h84);
    mem[10] = {OP_J, 26'h40};
    exp_rd(32'h00); exp_rd(32'h04); exp_rd(32'h08); exp_rd(32'h0C);
    exp_rd(32'h10); exp_rd(32'h1C); exp_rd(32'h20);
    exp_wr(32'h80, 32'd1);
    exp_rd(32'h24);
    exp_wr(32'h84, 32'd0);
    exp_rd(32'h28); exp_rd(32'h100);
    release_reset();
    repeat (32) @(posedge clk);
    #1;
    chk("p3_32cyc_pc", pc_out, 32'h100);
    chk("p3_32cyc_state", 32'(state_out), 32'd0);
    check_halt("p3", 32'h104);

    // Program 4: reset pulsed while lw is waiting for ack
    hold_reset();
    data_wait = 10;
    mem[0]  = enc_i(OP_LW, 0, 4, 'h40);
    mem[16] = 32'h1234_5678;
    exp_rd(32'h00);
    release_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("p4_mid_req", 32'(mem_req), 32'd1);
    chk("p4_mid_addr", mem_addr, 32'h40);
    #2 rst = 1'b1;
    #1;
    chk("p4_rst_req", 32'(mem_req), 32'd0);
    chk("p4_rst_state", 32'(state_out), 32'd0);
    chk("p4_rst_pc", pc_out, 32'h0);
    data_wait = 0;
    exp_rd(32'h00); exp_rd(32'h40); exp_rd(32'h04);
    repeat (2) @(posedge clk);
    release_reset();
    #1;
    chk("p4_restart_req", 32'(mem_req), 32'd1);
    chk("p4_restart_addr", mem_addr, 32'h0);
    check_halt("p4", 32'h08);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
